// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: synchronized go/clear/lap buttons, STOPPED/RUNNING/HALTED FSM and a
// prescaled BCD counter. Define STOPWATCH_LAP_EN to build the lap (display freeze) feature.

module stopwatch_ctrl #(
    parameter int NUM_DIGITS = 4,
    parameter int TICK_DIV   = 100000,
    parameter int WRAP_MODE  = 0
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    go,
    input  logic                    clear,
    input  logic                    lap,
    output logic [4*NUM_DIGITS-1:0] digits_o,
    output logic                    running,
    output logic                    lap_active,
    output logic                    overflow
);
    localparam int CW = 4 * NUM_DIGITS;
    localparam int PRE_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    localparam logic [1:0] ST_STOPPED = 2'd0;
    localparam logic [1:0] ST_RUNNING = 2'd1;
    localparam logic [1:0] ST_HALTED  = 2'd2;

    // Button bit order in the vectors below: [0]=go, [1]=clear, [2]=lap
    logic [2:0]       sync_p0, sync_p1, sync_p2, evt_p3, armed;
    logic [1:0]       settle;
    logic             settled;
    logic             go_evt, clr_evt, lap_evt;

    logic [1:0]       state_q;
    logic [PRE_W-1:0] pre_q;
    logic [CW-1:0]    count_q, count_inc;
    logic             all_nines, tick, halt_now;

    assign settled = (settle == 2'd2);
    assign {lap_evt, clr_evt, go_evt} = evt_p3;

    // A button only arms once its synchronized level has been seen low after reset,
    // so a button held through reset release never fires.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
            sync_p2 <= '0;
            evt_p3  <= '0;
            armed   <= '0;
            settle  <= '0;
        end else begin
            sync_p0 <= {lap, clear, go};
            sync_p1 <= sync_p0;
            sync_p2 <= sync_p1;
            if (!settled)
                settle <= settle + 2'd1;
            armed  <= armed | ({3{settled}} & ~sync_p1);
            evt_p3 <= sync_p1 & ~sync_p2 & armed;
        end
    end

    always_comb begin
        all_nines = 1'b1;
        count_inc = count_q;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (all_nines) begin
                if (count_q[4*i +: 4] == 4'd9) begin
                    count_inc[4*i +: 4] = 4'd0;
                end else begin
                    count_inc[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
                    all_nines = 1'b0;
                end
            end
        end
    end

    assign tick     = (state_q == ST_RUNNING) && (pre_q == PRE_LAST);
    assign halt_now = tick && all_nines && (WRAP_MODE == 0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_STOPPED;
            pre_q    <= '0;
            count_q  <= '0;
            overflow <= 1'b0;
        end else if (clr_evt) begin
            state_q  <= ST_STOPPED;
            pre_q    <= '0;
            count_q  <= '0;
            overflow <= 1'b0;
        end else begin
            // Wrap mode makes overflow a single-cycle pulse; halt mode keeps it sticky.
            if (WRAP_MODE != 0)
                overflow <= 1'b0;
            if (state_q == ST_RUNNING)
                pre_q <= tick ? '0 : pre_q + 1'b1;
            if (tick) begin
                if (all_nines)
                    overflow <= 1'b1;
                if (!halt_now)
                    count_q <= count_inc;
            end
            case (state_q)
                ST_STOPPED: if (go_evt) state_q <= ST_RUNNING;
                ST_RUNNING: begin
                    if (halt_now)
                        state_q <= ST_HALTED;
                    else if (go_evt)
                        state_q <= ST_STOPPED;
                end
                ST_HALTED:  state_q <= ST_HALTED;
                default:    state_q <= ST_STOPPED;
            endcase
        end
    end

    assign running = (state_q == ST_RUNNING);

`ifdef STOPWATCH_LAP_EN
    logic [CW-1:0] snap;
    logic          lap_set;

    assign lap_set = lap_evt && !clr_evt && (state_q == ST_RUNNING) && !lap_active;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            lap_active <= 1'b0;
        else if (clr_evt)
            lap_active <= 1'b0;
        else if (lap_evt)
            lap_active <= (state_q == ST_RUNNING) ? !lap_active : 1'b0;
    end

    always_ff @(posedge clk) begin
        if (lap_set)
            snap <= count_q;
    end

    assign digits_o = lap_active ? snap : count_q;
`else
    logic lap_unused;

    assign lap_unused = lap_evt;
    assign lap_active = 1'b0;
    assign digits_o   = count_q;
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: halt-mode and wrap-mode instances side by side, directed scenarios
// plus random button activity against a count-level reference model.

module tb_stopwatch_ctrl;
    localparam int TD = 4;
    localparam int MAXC = 99;
    localparam int ST_STOP = 0;
    localparam int ST_RUN = 1;
    localparam int ST_HALT = 2;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic go = 1'b0;
    logic clear = 1'b0;
    logic lap = 1'b0;
    logic [7:0] dig [2];
    logic run [2];
    logic lapa [2];
    logic ovf [2];

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: index 0 = halt-at-99 instance, 1 = wrap instance
    int m_st [2];
    int m_cnt [2];
    int m_pre [2];
    int m_snap [2];
    bit m_ovf [2];
    bit m_lapa [2];
    logic [2:0] hist [$];

    always #5 clk = ~clk;

    stopwatch_ctrl #(.NUM_DIGITS(2), .TICK_DIV(TD), .WRAP_MODE(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .go(go), .clear(clear), .lap(lap),
        .digits_o(dig[0]), .running(run[0]), .lap_active(lapa[0]), .overflow(ovf[0])
    );

    stopwatch_ctrl #(.NUM_DIGITS(2), .TICK_DIV(TD), .WRAP_MODE(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .go(go), .clear(clear), .lap(lap),
        .digits_o(dig[1]), .running(run[1]), .lap_active(lapa[1]), .overflow(ovf[1])
    );

    function automatic logic [7:0] bcd(input int c);
        return 8'(((c / 10) % 10) * 16 + (c % 10));
    endfunction

    function automatic void model_step(input int m, input bit ge, input bit ce, input bit le);
        int old_st;
        int old_cnt;
        bit tk;
        if (ce) begin
            m_st[m] = ST_STOP;
            m_cnt[m] = 0;
            m_pre[m] = 0;
            m_ovf[m] = 0;
            m_lapa[m] = 0;
            return;
        end
        old_st = m_st[m];
        old_cnt = m_cnt[m];
        tk = 0;
        if (m == 1) m_ovf[m] = 0;
        if (old_st == ST_RUN) begin
            if (m_pre[m] == TD - 1) begin
                m_pre[m] = 0;
                tk = 1;
            end else begin
                m_pre[m] = m_pre[m] + 1;
            end
        end
        if (tk) begin
            if (m_cnt[m] == MAXC) begin
                m_ovf[m] = 1;
                if (m == 0) m_st[m] = ST_HALT;
                else m_cnt[m] = 0;
            end else begin
                m_cnt[m] = m_cnt[m] + 1;
            end
        end
        if (ge) begin
            if (old_st == ST_STOP) m_st[m] = ST_RUN;
            else if (m_st[m] == ST_RUN) m_st[m] = ST_STOP;
        end
`ifdef STOPWATCH_LAP_EN
        if (le) begin
            if (old_st == ST_RUN) begin
                if (!m_lapa[m]) m_snap[m] = old_cnt;
                m_lapa[m] = !m_lapa[m];
            end else begin
                m_lapa[m] = 0;
            end
        end
`else
        if (le) m_lapa[m] = 0;
`endif
    endfunction

    // An input rise sampled on edge n acts on edge n+3; samples before reset release do not count.
    initial begin
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                hist.delete();
                for (int m = 0; m < 2; m++) begin
                    m_st[m] = ST_STOP;
                    m_cnt[m] = 0;
                    m_pre[m] = 0;
                    m_ovf[m] = 0;
                    m_lapa[m] = 0;
                end
            end else begin
                hist.push_back({lap, clear, go});
                if (hist.size() > 5) void'(hist.pop_front());
                for (int m = 0; m < 2; m++)
                    model_step(m,
                               hist.size() == 5 && hist[1][0] && !hist[0][0],
                               hist.size() == 5 && hist[1][1] && !hist[0][1],
                               hist.size() == 5 && hist[1][2] && !hist[0][2]);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        reset_n = 1'b0;
        go = 1'b0;
        clear = 1'b0;
        lap = 1'b0;
        repeat (3) @(negedge clk);
        for (int m = 0; m < 2; m++) begin
            n_cmp++; if (dig[m] !== 8'h00) begin n_bad++; $display("FAIL reset_digits dut%0d: got %h expected 00", m, dig[m]); end
            n_cmp++; if (run[m] !== 1'b0) begin n_bad++; $display("FAIL reset_running dut%0d: got %b expected 0", m, run[m]); end
            n_cmp++; if (lapa[m] !== 1'b0) begin n_bad++; $display("FAIL reset_lap dut%0d: got %b expected 0", m, lapa[m]); end
            n_cmp++; if (ovf[m] !== 1'b0) begin n_bad++; $display("FAIL reset_overflow dut%0d: got %b expected 0", m, ovf[m]); end
        end
        reset_n = 1'b1;
        repeat (6) @(negedge clk);
        for (int m = 0; m < 2; m++) begin
            n_cmp++; if (run[m] !== 1'b0) begin n_bad++; $display("FAIL idle_running dut%0d: got %b expected 0", m, run[m]); end
        end
    endtask

    task automatic test_start_latency();
        go = 1'b1;
        repeat (3) @(negedge clk);
        for (int m = 0; m < 2; m++) begin
            n_cmp++; if (run[m] !== 1'b0) begin n_bad++; $display("FAIL latency_early dut%0d: got %b expected 0", m, run[m]); end
        end
        @(negedge clk);
        for (int m = 0; m < 2; m++) begin
            n_cmp++; if (run[m] !== 1'b1) begin n_bad++; $display("FAIL latency_run dut%0d: got %b expected 1", m, run[m]); end
        end
        go = 1'b0;
        repeat (3) @(negedge clk);
        for (int m = 0; m < 2; m++) begin
            n_cmp++; if (dig[m] !== 8'h00) begin n_bad++; $display("FAIL first_tick_early dut%0d: got %h expected 00", m, dig[m]); end
        end
        @(negedge clk);
        for (int m = 0; m < 2; m++) begin
            n_cmp++; if (dig[m] !== 8'h01) begin n_bad++; $display("FAIL first_tick dut%0d: got %h expected 01", m, dig[m]); end
        end
    endtask

    task automatic test_stop_hold();
        int k;
        for (k = 0; k < 200 && !(m_cnt[0] == 8 && m_pre[0] == 1); k++) @(negedge clk);
        if (k >= 200) begin n_cmp++; n_bad++; $display("FAIL stop_wait: timeout waiting for count 08"); end
        go = 1'b1;
        @(negedge clk);
        @(negedge clk);
        go = 1'b0;
        @(negedge clk);
        for (int m = 0; m < 2; m++) begin
            n_cmp++; if (dig[m] !== 8'h09 || run[m] !== 1'b1) begin n_bad++; $display("FAIL stop_pre dut%0d: got %h/%b expected 09/1", m, dig[m], run[m]); end
        end
        @(negedge clk);
        for (int m = 0; m < 2; m++) begin
            n_cmp++; if (dig[m] !== 8'h09 || run[m] !== 1'b0) begin n_bad++; $display("FAIL stop_now dut%0d: got %h/%b expected 09/0", m, dig[m], run[m]); end
        end
        repeat (10) begin
            @(negedge clk);
            n_cmp++; if (dig[0] !== 8'h09 || run[0] !== 1'b0) begin n_bad++; $display("FAIL stop_hold: got %h/%b expected 09/0", dig[0], run[0]); end
        end
        go = 1'b1;
        @(negedge clk);
        @(negedge clk);
        go = 1'b0;
        repeat (4) @(negedge clk);
        for (int m = 0; m < 2; m++) begin
            n_cmp++; if (dig[m] !== 8'h09 || run[m] !== 1'b1) begin n_bad++; $display("FAIL resume_pre dut%0d: got %h/%b expected 09/1", m, dig[m], run[m]); end
        end
        @(negedge clk);
        for (int m = 0; m < 2; m++) begin
            n_cmp++; if (dig[m] !== 8'h10) begin n_bad++; $display("FAIL resume_tick dut%0d: got %h expected 10", m, dig[m]); end
        end
    endtask

    task automatic test_overflow();
        int k;
        for (k = 0; k < 1000 && dig[0] !== 8'h99; k++) @(negedge clk);
        if (k >= 1000) begin n_cmp++; n_bad++; $display("FAIL ovf_wait: timeout waiting for count 99"); end
        repeat (3) @(negedge clk);
        n_cmp++; if (dig[0] !== 8'h99 || run[0] !== 1'b1 || ovf[0] !== 1'b0) begin n_bad++; $display("FAIL ovf_before: got %h/%b/%b expected 99/1/0", dig[0], run[0], ovf[0]); end
        n_cmp++; if (ovf[1] !== 1'b0) begin n_bad++; $display("FAIL wrap_before: got %b expected 0", ovf[1]); end
        @(negedge clk);
        n_cmp++; if (dig[0] !== 8'h99 || run[0] !== 1'b0 || ovf[0] !== 1'b1) begin n_bad++; $display("FAIL halt: got %h/%b/%b expected 99/0/1", dig[0], run[0], ovf[0]); end
        n_cmp++; if (dig[1] !== 8'h00 || run[1] !== 1'b1 || ovf[1] !== 1'b1) begin n_bad++; $display("FAIL wrap: got %h/%b/%b expected 00/1/1", dig[1], run[1], ovf[1]); end
        @(negedge clk);
        n_cmp++; if (ovf[0] !== 1'b1) begin n_bad++; $display("FAIL halt_sticky: got %b expected 1", ovf[0]); end
        n_cmp++; if (dig[1] !== 8'h00 || run[1] !== 1'b1 || ovf[1] !== 1'b0) begin n_bad++; $display("FAIL wrap_pulse: got %h/%b/%b expected 00/1/0", dig[1], run[1], ovf[1]); end
        go = 1'b1;
        repeat (2) @(negedge clk);
        go = 1'b0;
        repeat (6) @(negedge clk);
        n_cmp++; if (dig[0] !== 8'h99 || run[0] !== 1'b0 || ovf[0] !== 1'b1) begin n_bad++; $display("FAIL halt_go_ignored: got %h/%b/%b expected 99/0/1", dig[0], run[0], ovf[0]); end
        clear = 1'b1;
        repeat (2) @(negedge clk);
        clear = 1'b0;
        repeat (4) @(negedge clk);
        for (int m = 0; m < 2; m++) begin
            n_cmp++; if (dig[m] !== 8'h00 || ovf[m] !== 1'b0 || run[m] !== 1'b0) begin n_bad++; $display("FAIL ovf_clear dut%0d: got %h/%b/%b expected 00/0/0", m, dig[m], ovf[m], run[m]); end
        end
    endtask

    task automatic test_clear_go_same();
        int k;
        go = 1'b1;
        repeat (2) @(negedge clk);
        go = 1'b0;
        for (k = 0; k < 200 && dig[0] !== 8'h05; k++) @(negedge clk);
        if (k >= 200) begin n_cmp++; n_bad++; $display("FAIL cg_wait: timeout waiting for count 05"); end
        clear = 1'b1;
        go = 1'b1;
        repeat (2) @(negedge clk);
        clear = 1'b0;
        go = 1'b0;
        repeat (4) @(negedge clk);
        for (int m = 0; m < 2; m++) begin
            n_cmp++; if (dig[m] !== 8'h00 || run[m] !== 1'b0) begin n_bad++; $display("FAIL clear_wins dut%0d: got %h/%b expected 00/0", m, dig[m], run[m]); end
        end
        repeat (10) @(negedge clk);
        for (int m = 0; m < 2; m++) begin
            n_cmp++; if (dig[m] !== 8'h00 || run[m] !== 1'b0) begin n_bad++; $display("FAIL go_discarded dut%0d: got %h/%b expected 00/0", m, dig[m], run[m]); end
        end
        go = 1'b1;
        repeat (2) @(negedge clk);
        go = 1'b0;
        for (k = 0; k < 200 && dig[0] !== 8'h03; k++) @(negedge clk);
        if (k >= 200) begin n_cmp++; n_bad++; $display("FAIL rst_wait: timeout waiting for count 03"); end
        @(negedge clk);
        go = 1'b1;
        reset_n = 1'b0;
        #1;
        for (int m = 0; m < 2; m++) begin
            n_cmp++; if (dig[m] !== 8'h00 || run[m] !== 1'b0 || lapa[m] !== 1'b0 || ovf[m] !== 1'b0) begin
                n_bad++; $display("FAIL async_reset dut%0d: got %h/%b/%b/%b expected 00/0/0/0", m, dig[m], run[m], lapa[m], ovf[m]);
            end
        end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (20) @(negedge clk);
        for (int m = 0; m < 2; m++) begin
            n_cmp++; if (dig[m] !== 8'h00 || run[m] !== 1'b0) begin n_bad++; $display("FAIL held_go dut%0d: got %h/%b expected 00/0", m, dig[m], run[m]); end
        end
        go = 1'b0;
        repeat (4) @(negedge clk);
        go = 1'b1;
        repeat (5) @(negedge clk);
        go = 1'b0;
        for (int m = 0; m < 2; m++) begin
            n_cmp++; if (run[m] !== 1'b1) begin n_bad++; $display("FAIL new_go dut%0d: got %b expected 1", m, run[m]); end
        end
    endtask

    task automatic test_lap();
        int k;
`ifdef STOPWATCH_LAP_EN
        for (k = 0; k < 200 && !(m_cnt[0] == 11 && m_pre[0] == 2); k++) @(negedge clk);
        if (k >= 200) begin n_cmp++; n_bad++; $display("FAIL lap_wait: timeout waiting for count 11"); end
        lap = 1'b1;
        @(negedge clk);
        @(negedge clk);
        lap = 1'b0;
        @(negedge clk);
        @(negedge clk);
        for (int m = 0; m < 2; m++) begin
            n_cmp++; if (lapa[m] !== 1'b1 || dig[m] !== 8'h12) begin n_bad++; $display("FAIL lap_set dut%0d: got %b/%h expected 1/12", m, lapa[m], dig[m]); end
        end
        for (int i = 1; i < 20; i++) begin
            @(negedge clk);
            n_cmp++; if (dig[0] !== 8'h12) begin n_bad++; $display("FAIL lap_frozen: got %h expected 12", dig[0]); end
            if (i == 16) lap = 1'b1;
            if (i == 18) lap = 1'b0;
        end
        @(negedge clk);
        for (int m = 0; m < 2; m++) begin
            n_cmp++; if (lapa[m] !== 1'b0 || dig[m] !== 8'h17) begin n_bad++; $display("FAIL lap_release dut%0d: got %b/%h expected 0/17", m, lapa[m], dig[m]); end
        end
`else
        for (k = 0; k < 200 && dig[0] !== 8'h03; k++) @(negedge clk);
        if (k >= 200) begin n_cmp++; n_bad++; $display("FAIL lap_wait: timeout waiting for count 03"); end
        lap = 1'b1;
        repeat (2) @(negedge clk);
        lap = 1'b0;
        repeat (6) begin
            @(negedge clk);
            for (int m = 0; m < 2; m++) begin
                n_cmp++; if (lapa[m] !== 1'b0 || dig[m] !== bcd(m_cnt[m])) begin
                    n_bad++; $display("FAIL lap_ignored dut%0d: got %b/%h expected 0/%h", m, lapa[m], dig[m], bcd(m_cnt[m]));
                end
            end
        end
`endif
    endtask

    task automatic test_random();
        logic [7:0] exp_dig;
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            for (int m = 0; m < 2; m++) begin
                exp_dig = m_lapa[m] ? bcd(m_snap[m]) : bcd(m_cnt[m]);
                n_cmp++; if (dig[m] !== exp_dig) begin n_bad++; $display("FAIL rand_digits dut%0d cyc %0d: got %h expected %h", m, c, dig[m], exp_dig); end
                n_cmp++; if (run[m] !== (m_st[m] == ST_RUN)) begin n_bad++; $display("FAIL rand_running dut%0d cyc %0d: got %b expected %b", m, c, run[m], m_st[m] == ST_RUN); end
                n_cmp++; if (lapa[m] !== m_lapa[m]) begin n_bad++; $display("FAIL rand_lap dut%0d cyc %0d: got %b expected %b", m, c, lapa[m], m_lapa[m]); end
                n_cmp++; if (ovf[m] !== m_ovf[m]) begin n_bad++; $display("FAIL rand_overflow dut%0d cyc %0d: got %b expected %b", m, c, ovf[m], m_ovf[m]); end
            end
            if ($urandom_range(0, 11) == 0) go = ~go;
            if ($urandom_range(0, 59) == 0) clear = ~clear;
            if ($urandom_range(0, 15) == 0) lap = ~lap;
            if (!reset_n) reset_n = 1'b1;
            else if ($urandom_range(0, 499) == 0) reset_n = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_start_latency();
        test_stop_hold();
        test_overflow();
        test_clear_go_same();
        test_lap();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
